// File: rtl/lcd_ula_driver_pkg.sv
// lcd_pkg: HD44780 command/character constants, FSM enums and helper functions
// shared by the LCD result driver and its binary-to-BCD converter.
// Pure declarations, no state.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
   localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
   localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;
   localparam logic [7:0] CMD_CLEAR        = 8'h01;
   localparam logic [7:0] CMD_LINE1        = 8'h80;

   localparam logic [7:0] CHR_SPACE = 8'h20;
   localparam logic [7:0] CHR_MINUS = 8'h2D;
   localparam logic [7:0] CHR_ZERO  = 8'h30;

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT,
      ST_IDLE,
      ST_CONVERT,
      ST_WRITE
   } main_st_t;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_HOLD
   } byte_ph_t;

   // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
   function automatic logic [35:0] dabble_step(input logic [35:0] sr);
      logic [35:0] t;
      t = sr;
      for (int i = 0; i < 5; i++) begin
         if (t[16 + 4*i +: 4] >= 4'd5)
            t[16 + 4*i +: 4] = t[16 + 4*i +: 4] + 4'd3;
      end
      return {t[34:0], 1'b0};
   endfunction

   // {RS, data} for byte idx of the INIT or WRITE sequence.
   // WRITE: 0 = cursor home, 1 = sign, 2..6 = digits MSD first, leading zeros blanked.
   function automatic logic [8:0] lcd_byte(input main_st_t st, input logic [2:0] idx,
                                           input logic neg, input logic [19:0] bcd);
      logic [8:0]  b;
      logic [19:0] upper;
      logic [4:0]  sh;
      sh    = {(3'd6 - idx), 2'b00};
      upper = bcd >> sh;
      if (st == ST_INIT) begin
         case (idx)
            3'd0:    b = {1'b0, CMD_FUNC_8BIT_2L};
            3'd1:    b = {1'b0, CMD_DISP_ON};
            3'd2:    b = {1'b0, CMD_ENTRY_INC};
            default: b = {1'b0, CMD_CLEAR};
         endcase
      end else if (idx == 3'd0) begin
         b = {1'b0, CMD_LINE1};
      end else if (idx == 3'd1) begin
         b = {1'b1, (neg ? CHR_MINUS : CHR_SPACE)};
      end else if (upper == 20'd0 && idx != 3'd6) begin
         b = {1'b1, CHR_SPACE};
      end else begin
         b = {1'b1, CHR_ZERO + {4'd0, upper[3:0]}};
      end
      return b;
   endfunction

endpackage

// File: rtl/lcd_ula_driver_bin2bcd16.sv
// bin2bcd16: sequential double-dabble, 16-bit binary to 5 BCD digits.
// Latency: done pulses exactly 16 cycles after an accepted start.
// Backpressure: none; a start while busy is ignored, bcd holds until next start.
module bin2bcd16
   import lcd_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] bin,
   output logic        done,
   output logic [19:0] bcd
);

   logic [35:0] sr;
   logic [35:0] sr_nxt;
   logic [3:0]  cnt;
   logic        busy;

   assign sr_nxt = dabble_step(sr);

   // Load on start, then 16 shift/correct steps; publish result with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr   <= '0;
         cnt  <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         bcd  <= '0;
      end else begin
         done <= 1'b0;
         if (!busy) begin
            if (start) begin
               sr   <= {20'd0, bin};
               cnt  <= '0;
               busy <= 1'b1;
            end
         end else begin
            sr  <= sr_nxt;
            cnt <= cnt + 4'd1;
            if (cnt == 4'd15) begin
               busy <= 1'b0;
               done <= 1'b1;
               bcd  <= sr_nxt[35:16];
            end
         end
      end
   end

endmodule

// File: rtl/lcd_ula_driver.sv
// lcd_ula_driver: shows the signed calculator result on a 16x2 HD44780 LCD (8-bit mode).
// Latency: power-up wait + init once, then ~17 cycles convert + 7 byte transfers per update.
// Backpressure: none; input changes during an update are picked up on the next IDLE compare.
module lcd_ula_driver
   import lcd_pkg::*;
#(
   parameter int unsigned T_POWERUP = 750000,
   parameter int unsigned T_EN      = 25,
   parameter int unsigned T_CMD     = 2500,
   parameter int unsigned T_CLEAR   = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] saida,
   input  logic        sinal_saida,
   output logic        EN,
   output logic        RS,
   output logic        RW,
   output logic [7:0]  data,
   output logic        ocupado
);

   localparam int unsigned T_A    = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
   localparam int unsigned T_B    = (T_CMD > T_EN) ? T_CMD : T_EN;
   localparam int unsigned T_MAX  = (T_A > T_B) ? T_A : T_B;
   localparam int unsigned TW     = $clog2(T_MAX + 1);

   main_st_t    st;
   byte_ph_t    ph;
   logic [TW-1:0] timer;
   logic [TW-1:0] hold_lim;
   logic [2:0]  idx;
   logic [16:0] snapshot;
   logic        shown_valid;
   logic        start;
   logic        done;
   logic [19:0] bcd;
   logic        neg;
   logic        last_byte;
   logic [8:0]  next_byte;

   assign RW = 1'b0;

   // Zero is never displayed with a minus sign.
   assign neg       = snapshot[16] && (snapshot[15:0] != 16'd0);
   assign hold_lim  = (!RS && data == CMD_CLEAR) ? TW'(T_CLEAR - 1) : TW'(T_CMD - 1);
   assign last_byte = (st == ST_INIT) ? (idx == 3'd3) : (idx == 3'd6);
   assign next_byte = lcd_byte(st, idx + 3'd1, neg, bcd);

   bin2bcd16 u_bcd (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bin   (snapshot[15:0]),
      .done  (done),
      .bcd   (bcd)
   );

   // Main sequencer: power-up wait, init commands, idle compare, convert, write line 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st          <= ST_POWERUP;
         ph          <= PH_SETUP;
         timer       <= '0;
         idx         <= '0;
         EN          <= 1'b0;
         RS          <= 1'b0;
         data        <= 8'h00;
         ocupado     <= 1'b1;
         snapshot    <= '0;
         shown_valid <= 1'b0;
         start       <= 1'b0;
      end else begin
         start <= 1'b0;
         case (st)
            ST_POWERUP: begin
               if (timer == TW'(T_POWERUP - 1)) begin
                  st          <= ST_INIT;
                  ph          <= PH_SETUP;
                  timer       <= '0;
                  idx         <= '0;
                  {RS, data}  <= lcd_byte(ST_INIT, 3'd0, 1'b0, 20'd0);
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_INIT, ST_WRITE: begin
               case (ph)
                  PH_SETUP: begin
                     EN    <= 1'b1;
                     ph    <= PH_PULSE;
                     timer <= '0;
                  end
                  PH_PULSE: begin
                     if (timer == TW'(T_EN - 1)) begin
                        EN    <= 1'b0;
                        ph    <= PH_HOLD;
                        timer <= '0;
                     end else begin
                        timer <= timer + 1'b1;
                     end
                  end
                  PH_HOLD: begin
                     if (timer == hold_lim) begin
                        timer <= '0;
                        if (last_byte) begin
                           st      <= ST_IDLE;
                           ocupado <= 1'b0;
                           if (st == ST_WRITE)
                              shown_valid <= 1'b1;
                        end else begin
                           idx        <= idx + 3'd1;
                           ph         <= PH_SETUP;
                           {RS, data} <= next_byte;
                        end
                     end else begin
                        timer <= timer + 1'b1;
                     end
                  end
                  default: ph <= PH_SETUP;
               endcase
            end
            ST_IDLE: begin
               if (!shown_valid || ({sinal_saida, saida} != snapshot)) begin
                  st       <= ST_CONVERT;
                  snapshot <= {sinal_saida, saida};
                  start    <= 1'b1;
                  ocupado  <= 1'b1;
               end
            end
            ST_CONVERT: begin
               if (done) begin
                  st         <= ST_WRITE;
                  ph         <= PH_SETUP;
                  timer      <= '0;
                  idx        <= '0;
                  {RS, data} <= lcd_byte(ST_WRITE, 3'd0, neg, bcd);
               end
            end
            default: st <= ST_POWERUP;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_ula_driver.sv
// tb_lcd_ula_driver: directed bench for the LCD result driver with short timing parameters.
// Bytes are captured at EN falling edges together with their EN rise/fall cycle stamps.
// Expected byte streams are hand-computed constants.
module tb_lcd_ula_driver;

   localparam int TP  = 20;
   localparam int TE  = 2;
   localparam int TC  = 5;
   localparam int TCL = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] saida = 16'd0;
   logic        sinal_saida = 1'b0;
   logic        EN, RS, RW, ocupado;
   logic [7:0]  data;

   always #5 clk = ~clk;

   lcd_ula_driver #(
      .T_POWERUP (TP),
      .T_EN      (TE),
      .T_CMD     (TC),
      .T_CLEAR   (TCL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .saida       (saida),
      .sinal_saida (sinal_saida),
      .EN          (EN),
      .RS          (RS),
      .RW          (RW),
      .data        (data),
      .ocupado     (ocupado)
   );

   typedef struct {
      logic       rs;
      logic       rs_fall;
      logic [7:0] d_rise;
      logic [7:0] d_fall;
      int         rise;
      int         fall;
   } byte_rec_t;

   typedef struct {
      logic [15:0] mag;
      logic        sgn;
      logic [47:0] chars;
   } vec_t;

   byte_rec_t bq[$];
   int        ofq[$];
   int        lq[$];
   int        cyc = 0;
   int        n_tests = 0;
   int        n_fail = 0;

   // Monitor: stamp EN pulses and ocupado low intervals on the falling clock edge.
   initial begin
      byte_rec_t cur;
      logic prev_en, prev_ocu;
      int   ofall;
      prev_en = 1'b0;
      prev_ocu = 1'b1;
      ofall = 0;
      cur = '{default: 0};
      forever begin
         @(negedge clk);
         cyc++;
         assert (RW == 1'b0) else $error("RW driven high at cycle %0d", cyc);
         if (EN && !prev_en) begin
            cur.rise = cyc;
            cur.rs = RS;
            cur.d_rise = data;
         end
         if (!EN && prev_en) begin
            cur.fall = cyc;
            cur.rs_fall = RS;
            cur.d_fall = data;
            bq.push_back(cur);
         end
         if (!ocupado && prev_ocu) begin
            ofall = cyc;
            ofq.push_back(cyc);
         end
         if (ocupado && !prev_ocu)
            lq.push_back(cyc - ofall);
         prev_en = EN;
         prev_ocu = ocupado;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, expv, expv);
      end
   endtask

   task automatic wait_bytes(input int n);
      int k = 0;
      while (bq.size() < n && k < 3000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("byte_count", bq.size() >= n ? 1 : 0, 1);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (ocupado !== 1'b0 && k < 3000) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("reach_idle", int'(ocupado), 0);
   endtask

   task automatic check_init(input int base);
      logic [31:0] cmds;
      cmds = 32'h380C0601;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("init%0d_rs", j), int'(bq[base+j].rs), 0);
         chk($sformatf("init%0d_data", j), int'(bq[base+j].d_fall), int'(cmds[31-8*j -: 8]));
      end
   endtask

   // Seven-byte line write: 0x80 command, then six RS=1 characters with 8-cycle spacing.
   task automatic check_update(input int base, input logic [47:0] chars, input string tag);
      chk({tag, "_cmd"}, int'({bq[base].rs, bq[base].d_fall}), 9'h080);
      for (int j = 0; j < 7; j++) begin
         chk($sformatf("%s_b%0d_en_width", tag, j), bq[base+j].fall - bq[base+j].rise, TE);
         chk($sformatf("%s_b%0d_stable", tag, j),
             int'({bq[base+j].rs_fall, bq[base+j].d_fall}), int'({bq[base+j].rs, bq[base+j].d_rise}));
         if (j > 0) begin
            chk($sformatf("%s_b%0d_char", tag, j),
                int'({bq[base+j].rs, bq[base+j].d_fall}), int'({1'b1, chars[8*(7-j)-1 -: 8]}));
            chk($sformatf("%s_b%0d_period", tag, j), bq[base+j].rise - bq[base+j-1].rise, 1 + TE + TC);
         end
      end
   endtask

   initial begin
      vec_t vt[4];
      int   base, obase, lbase, c0, k;

      vt[0] = '{16'd12345, 1'b1, 48'h2D3132333435};
      vt[1] = '{16'd0,     1'b1, 48'h202020202030};
      vt[2] = '{16'd100,   1'b1, 48'h2D2020313030};
      vt[3] = '{16'd65535, 1'b0, 48'h203635353335};

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_en", int'(EN), 0);
      chk("rst_rs", int'(RS), 0);
      chk("rst_data", int'(data), 0);
      chk("rst_ocupado", int'(ocupado), 1);

      // Power-up, init, first display of 0
      @(negedge clk);
      rst = 1'b0;
      #1;
      c0 = cyc;
      base = bq.size();
      obase = ofq.size();
      lbase = lq.size();
      wait_bytes(base + 11);
      wait_idle();
      chk("powerup_first_rise", bq[base].rise - c0, TP + 1);
      check_init(base);
      chk("clear_hold", ofq[obase] - bq[base+3].fall, TCL);
      chk("idle_after_init", lq[lbase], 1);
      check_update(base + 4, 48'h202020202030, "zero");

      // Table-driven value changes while idle
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         saida = vt[i].mag;
         sinal_saida = vt[i].sgn;
         base = bq.size();
         wait_bytes(base + 7);
         wait_idle();
         check_update(base, vt[i].chars, $sformatf("vec%0d", i));
      end

      // Input changes 7 -> 42 while 7 is being written
      @(negedge clk);
      saida = 16'd7;
      sinal_saida = 1'b0;
      base = bq.size();
      wait_bytes(base + 2);
      saida = 16'd42;
      wait_bytes(base + 14);
      wait_idle();
      check_update(base, 48'h202020202037, "seven");
      check_update(base + 7, 48'h202020203432, "fortytwo");
      chk("busy_gap", lq[lq.size()-1], 1);
      repeat (40) @(negedge clk);
      #1;
      chk("no_extra_update", bq.size() - base, 14);

      // Asynchronous reset in the middle of a write, with EN high
      @(negedge clk);
      saida = 16'd999;
      sinal_saida = 1'b1;
      base = bq.size();
      wait_bytes(base + 2);
      k = 0;
      while (EN !== 1'b1 && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      chk("en_high_before_reset", int'(EN), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_en", int'(EN), 0);
      chk("mid_rst_rs", int'(RS), 0);
      chk("mid_rst_data", int'(data), 0);
      chk("mid_rst_ocupado", int'(ocupado), 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      c0 = cyc;
      base = bq.size();
      wait_bytes(base + 11);
      wait_idle();
      chk("re_powerup_first_rise", bq[base].rise - c0, TP + 1);
      check_init(base);
      check_update(base + 4, 48'h2D2020393939, "after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
